// File: rtl/perf_event_tracker_if.sv
// rtl/perf_event_tracker_if.sv - pipeline control inputs and perf-counter outputs of the event tracker
interface perf_event_tracker_if #(
  parameter int IW = 4
);
  logic          enable;
  logic          halt;
  logic          fetch_valid;
  logic          fetch_stall;
  logic          retire_valid;
  logic          flush;
  logic [2:0]    flush_num;
  logic          start_instr;
  logic          end_instr;
  logic [IW-1:0] inflight;
  logic [31:0]   stall_cycles;
  logic [1:0]    state;
  logic          done;
  logic          err;

  modport master (
    output enable, halt, fetch_valid, fetch_stall, retire_valid, flush, flush_num,
    input  start_instr, end_instr, inflight, stall_cycles, state, done, err
  );

  modport slave (
    input  enable, halt, fetch_valid, fetch_stall, retire_valid, flush, flush_num,
    output start_instr, end_instr, inflight, stall_cycles, state, done, err
  );
endinterface

// File: rtl/perf_event_tracker.sv
// rtl/perf_event_tracker.sv - start/end pulse generator, in-flight tracker and window FSM
// Optional stall-cycle counter enabled by PERF_STALL_COUNT_EN.
module perf_event_tracker #(
  parameter int MAX_INFLIGHT = 5,
  parameter int IW           = 4
) (
  input  logic                clk,
  input  logic                rst,
  perf_event_tracker_if.slave bus
);
  localparam int SW = IW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] inflight_q, inflight_d;
  logic          start_q, end_q, done_q, err_q, err_d;
  logic          in_run, in_drain, accept, retire;
  logic [SW-1:0] squash, sum;

  assign in_run   = (state_q == RUN);
  assign in_drain = (state_q == DRAIN);
  assign accept   = bus.fetch_valid && !bus.fetch_stall && !bus.flush && in_run;
  assign retire   = bus.retire_valid && (in_run || in_drain);
  assign squash   = (bus.flush && (in_run || in_drain)) ? SW'(bus.flush_num) : '0;
  // Two's-complement sum one bit wider than the count; the MSB flags underflow.
  assign sum      = {1'b0, inflight_q} + SW'(accept) - SW'(retire) - squash;

  always_comb begin
    err_d      = err_q;
    inflight_d = sum[IW-1:0];
    if (sum[SW-1]) begin
      inflight_d = '0;
      err_d      = 1'b1;
    end else if (sum[IW-1:0] > IW'(MAX_INFLIGHT)) begin
      inflight_d = IW'(MAX_INFLIGHT);
      err_d      = 1'b1;
    end

    state_d = state_q;
    case (state_q)
      IDLE:  if (bus.enable) state_d = RUN;
      RUN: begin
        if (!bus.enable) begin
          state_d    = IDLE;
          inflight_d = '0;
        end else if (bus.halt) begin
          state_d = DRAIN;
        end
      end
      DRAIN: if (inflight_d == '0) state_d = DONE;
      DONE:  if (!bus.enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= '0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      start_q    <= accept;
      end_q      <= retire;
      done_q     <= (state_d == DONE);
      err_q      <= err_d;
    end
  end

`ifdef PERF_STALL_COUNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (in_run && bus.fetch_valid && bus.fetch_stall && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign bus.stall_cycles = stall_q;
`else
  assign bus.stall_cycles = '0;
`endif

  assign bus.start_instr = start_q;
  assign bus.end_instr   = end_q;
  assign bus.inflight    = inflight_q;
  assign bus.state       = state_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_perf_event_tracker.sv
// tb/tb_perf_event_tracker.sv - directed and randomized checks of perf_event_tracker against a reference model
module tb_perf_event_tracker;
  localparam int MAXI = 5;
  localparam int IW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  perf_event_tracker_if #(.IW(IW)) bus ();

  perf_event_tracker #(.MAX_INFLIGHT(MAXI), .IW(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: window phase 0..3, in-flight count as plain integers.
  int      m_state = 0;
  int      m_infl  = 0;
  bit      m_err   = 0;
  longint  m_stall = 0;
  bit      m_start = 0;
  bit      m_end   = 0;
  bit      m_done  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model();
    bit     active, acc, ret;
    int     n, ns;
    if (rst) begin
      m_state = 0; m_infl = 0; m_err = 0; m_stall = 0;
      m_start = 0; m_end = 0; m_done = 0;
      return;
    end
    active = (m_state == 1) || (m_state == 2);
    acc = bus.fetch_valid && !bus.fetch_stall && !bus.flush && (m_state == 1);
    ret = bus.retire_valid && active;
    n = m_infl + int'(acc) - int'(ret) - ((bus.flush && active) ? int'(bus.flush_num) : 0);
    if (n < 0)    begin n = 0;    m_err = 1; end
    if (n > MAXI) begin n = MAXI; m_err = 1; end
    if (m_state == 1 && bus.fetch_valid && bus.fetch_stall && m_stall < 64'hFFFF_FFFF)
      m_stall++;
    ns = m_state;
    if (m_state == 0) begin
      if (bus.enable) ns = 1;
    end else if (m_state == 1) begin
      if (!bus.enable) begin ns = 0; n = 0; end
      else if (bus.halt) ns = 2;
    end else if (m_state == 2) begin
      if (n == 0) ns = 3;
    end else begin
      if (!bus.enable) ns = 0;
    end
    m_state = ns;
    m_infl  = n;
    m_start = acc;
    m_end   = ret;
    m_done  = (ns == 3);
  endtask

  task automatic check_all();
    longint exp_stall;
`ifdef PERF_STALL_COUNT_EN
    exp_stall = m_stall;
`else
    exp_stall = 0;
`endif
    chk("start_instr",  64'(bus.start_instr),  64'(m_start));
    chk("end_instr",    64'(bus.end_instr),    64'(m_end));
    chk("inflight",     64'(bus.inflight),     64'(m_infl));
    chk("stall_cycles", 64'(bus.stall_cycles), 64'(exp_stall));
    chk("state",        64'(bus.state),        64'(m_state));
    chk("done",         64'(bus.done),         64'(m_done));
    chk("err",          64'(bus.err),          64'(m_err));
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input bit en, input bit h, input bit fv, input bit fs,
                       input bit rv, input bit fl, input logic [2:0] fn);
    bus.enable = en; bus.halt = h; bus.fetch_valid = fv; bus.fetch_stall = fs;
    bus.retire_valid = rv; bus.flush = fl; bus.flush_num = fn;
  endtask

  initial begin
    int n_s, n_e;
    drive(0, 0, 0, 0, 0, 0, 3'd0);

    // Reset values
    rst = 1'b1;
    step();
    step();
    chk("rst_state", 64'(bus.state), 64'd0);
    chk("rst_inflight", 64'(bus.inflight), 64'd0);
    chk("rst_err", 64'(bus.err), 64'd0);
    rst = 1'b0;

    // Open window, three fetches, three retires
    drive(1, 0, 0, 0, 0, 0, 3'd0);
    step();
    chk("enter_run", 64'(bus.state), 64'd1);
    drive(1, 0, 1, 0, 0, 0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fetch3_start", 64'(bus.start_instr), 64'd1);
    end
    chk("fetch3_inflight", 64'(bus.inflight), 64'd3);
    drive(1, 0, 0, 0, 1, 0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("retire3_end", 64'(bus.end_instr), 64'd1);
    end
    chk("retire3_inflight", 64'(bus.inflight), 64'd0);

    // Steady fetch+retire with one instruction in flight
    drive(1, 0, 1, 0, 0, 0, 3'd0);
    step();
    drive(1, 0, 1, 0, 1, 0, 3'd0);
    n_s = 0; n_e = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      n_s += int'(bus.start_instr);
      n_e += int'(bus.end_instr);
      chk("steady_inflight", 64'(bus.inflight), 64'd1);
    end
    chk("steady_starts", 64'(n_s), 64'd10);
    chk("steady_ends", 64'(n_e), 64'd10);
    drive(1, 0, 0, 0, 1, 0, 3'd0);
    step();

    // Flush of 3 plus retire with four in flight; coincident fetch squashed
    drive(1, 0, 1, 0, 0, 0, 3'd0);
    for (int i = 0; i < 4; i++) step();
    chk("pre_flush_inflight", 64'(bus.inflight), 64'd4);
    drive(1, 0, 1, 0, 1, 1, 3'd3);
    step();
    chk("flush_inflight", 64'(bus.inflight), 64'd0);
    chk("flush_end", 64'(bus.end_instr), 64'd1);
    chk("flush_start", 64'(bus.start_instr), 64'd0);
    chk("flush_err", 64'(bus.err), 64'd0);

    // Halt with two in flight, drain, done, close window
    drive(1, 0, 1, 0, 0, 0, 3'd0);
    step();
    step();
    drive(1, 1, 0, 0, 0, 0, 3'd0);
    step();
    chk("halt_drain", 64'(bus.state), 64'd2);
    drive(1, 0, 1, 0, 1, 0, 3'd0);
    step();
    chk("drain_no_start", 64'(bus.start_instr), 64'd0);
    chk("drain_inflight", 64'(bus.inflight), 64'd1);
    drive(1, 0, 0, 0, 1, 0, 3'd0);
    step();
    chk("drain_done_end", 64'(bus.end_instr), 64'd1);
    chk("drain_done_state", 64'(bus.state), 64'd3);
    chk("drain_done_flag", 64'(bus.done), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 3'd0);
    step();
    chk("done_to_idle", 64'(bus.state), 64'd0);

    // Retire underflow sets sticky err
    drive(1, 0, 0, 0, 0, 0, 3'd0);
    step();
    drive(1, 0, 0, 0, 1, 0, 3'd0);
    step();
    chk("underflow_err", 64'(bus.err), 64'd1);
    chk("underflow_inflight", 64'(bus.inflight), 64'd0);
    drive(1, 0, 0, 0, 0, 0, 3'd0);
    step();
    chk("err_sticky", 64'(bus.err), 64'd1);

    // Four stalled fetches
    drive(1, 0, 1, 1, 0, 0, 3'd0);
    for (int i = 0; i < 4; i++) step();
`ifdef PERF_STALL_COUNT_EN
    chk("stall_count", 64'(bus.stall_cycles), 64'd4);
`else
    chk("stall_count", 64'(bus.stall_cycles), 64'd0);
`endif

    // Reset mid-RUN
    drive(1, 0, 1, 0, 0, 0, 3'd0);
    step();
    rst = 1'b1;
    step();
    chk("midrst_state", 64'(bus.state), 64'd0);
    chk("midrst_inflight", 64'(bus.inflight), 64'd0);
    chk("midrst_start", 64'(bus.start_instr), 64'd0);
    chk("midrst_err", 64'(bus.err), 64'd0);
    chk("midrst_stall", 64'(bus.stall_cycles), 64'd0);
    rst = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      drive(($urandom_range(0, 39) != 0),
            ($urandom_range(0, 29) == 0),
            ($urandom_range(0, 2) != 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 11) == 0),
            3'($urandom_range(0, 4)));
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
